// File: rtl/r_format_mc_cpu.sv
// r_format_mc_cpu -- multi-cycle MIPS R-format integer core.
//
// Each instruction walks FETCH -> DECODE -> EXEC -> WB. FETCH waits for a
// valid instruction. The other three states each take one cycle.
// Writeback is registered, so wb_valid/err pulse in the cycle after WB.
// That gives 3 cycles from the acceptance edge to the pulse. At that point
// the register file already holds the new value.
//
// Ports
//   clk, rst_n    single rising-edge clock, async active-low reset
//   instr_valid   source presents instr
//   instr[31:0]   R-format word {op, rs, rt, rd, shamt, funct}
//   instr_ready   core accepts an instruction this cycle (FETCH only)
//   pc_out        address of the next instruction to fetch
//   wb_valid      one-cycle pulse: register write (wb_addr, wb_data)
//   err           one-cycle pulse: illegal instruction or signed overflow
//   dbg_addr      combinational register-file read port address
//   dbg_data      read data for dbg_addr (register 0 always reads 0)
module r_format_mc_cpu #(
  parameter  int DATA_W  = 32,
  parameter  int REG_NUM = 32,
  parameter  int ADDR_W  = 32,
  parameter  int PC_STEP = 4,
  localparam int RA_W    = (REG_NUM > 1) ? $clog2(REG_NUM) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  input  logic [31:0]       instr,
  output logic              instr_ready,
  output logic [ADDR_W-1:0] pc_out,
  output logic              wb_valid,
  output logic [RA_W-1:0]   wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              err,
  input  logic [RA_W-1:0]   dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  localparam int MSB = DATA_W - 1;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2A;
  localparam logic [5:0] F_SLTU = 6'h2B;

  typedef enum logic [1:0] {FETCH, DECODE, EXEC, WB} state_t;

  typedef struct packed {
    logic [5:0] op;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rd;
    logic [4:0] shamt;
    logic [5:0] funct;
  } rinstr_t;

  state_t                           state;
  rinstr_t                          ir;
  logic [REG_NUM-1:0][DATA_W-1:0]   regs;
  logic [DATA_W-1:0]                op_a, op_b, res_q;
  logic                             bad_q;

  // Register specifiers only use their low RA_W bits.
  logic [RA_W-1:0] rs_idx, rt_idx, rd_idx;
  assign rs_idx = ir.rs[RA_W-1:0];
  assign rt_idx = ir.rt[RA_W-1:0];
  assign rd_idx = ir.rd[RA_W-1:0];

  assign instr_ready = (state == FETCH);
  assign dbg_data    = regs[dbg_addr];

  // ---------------- EXEC-stage ALU (operates on A/B latched in DECODE)
  logic [DATA_W-1:0] sum, diff, alu_res;
  logic              alu_ovf, alu_legal, sh_big;

  assign sum  = op_a + op_b;
  assign diff = op_a - op_b;
  // shamt is 5 bits, so it can exceed a narrow datapath. Those shifts
  // saturate instead of being reduced modulo the width.
  assign sh_big = (32'(ir.shamt) >= 32'(DATA_W));

  always_comb begin
    alu_res   = '0;
    alu_ovf   = 1'b0;
    alu_legal = 1'b1;
    case (ir.funct)
      F_ADD: begin
        alu_res = sum;
        alu_ovf = (op_a[MSB] == op_b[MSB]) && (sum[MSB] != op_a[MSB]);
      end
      F_ADDU: alu_res = sum;
      F_SUB: begin
        alu_res = diff;
        alu_ovf = (op_a[MSB] != op_b[MSB]) && (diff[MSB] != op_a[MSB]);
      end
      F_SUBU: alu_res = diff;
      F_AND:  alu_res = op_a & op_b;
      F_OR:   alu_res = op_a | op_b;
      F_XOR:  alu_res = op_a ^ op_b;
      F_NOR:  alu_res = ~(op_a | op_b);
      F_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      F_SLTU: alu_res = {{(DATA_W-1){1'b0}}, (op_a < op_b)};
      F_SLL:  alu_res = sh_big ? '0 : (op_b << ir.shamt);
      F_SRL:  alu_res = sh_big ? '0 : (op_b >> ir.shamt);
      F_SRA:  alu_res = sh_big ? {DATA_W{op_b[MSB]}}
                               : DATA_W'($signed(op_b) >>> ir.shamt);
      default: alu_legal = 1'b0;
    endcase
  end

  // ---------------- FSM, register file and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FETCH;
      pc_out   <= '0;
      ir       <= '0;
      regs     <= '0;
      op_a     <= '0;
      op_b     <= '0;
      res_q    <= '0;
      bad_q    <= 1'b0;
      wb_valid <= 1'b0;
      wb_addr  <= '0;
      wb_data  <= '0;
      err      <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      err      <= 1'b0;
      case (state)
        FETCH: begin
          if (instr_valid) begin
            ir     <= rinstr_t'(instr);
            pc_out <= pc_out + ADDR_W'(PC_STEP);
            state  <= DECODE;
          end
        end
        DECODE: begin
          op_a  <= regs[rs_idx];
          op_b  <= regs[rt_idx];
          state <= EXEC;
        end
        EXEC: begin
          res_q <= alu_res;
          bad_q <= (ir.op != 6'd0) || !alu_legal || alu_ovf;
          state <= WB;
        end
        WB: begin
          if (bad_q) begin
            err <= 1'b1;
          end else begin
            wb_valid <= 1'b1;
            wb_addr  <= rd_idx;
            wb_data  <= res_q;
            // Register 0 stays zero. The pulse still reports the result.
            if (rd_idx != '0) regs[rd_idx] <= res_q;
          end
          state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_r_format_mc_cpu.sv
// Scoreboard bench for r_format_mc_cpu. It runs a 32-bit default instance
// and a DATA_W=16 / REG_NUM=8 / ADDR_W=8 instance. Stimulus pushes the
// expected writeback per accepted instruction. A monitor per instance pops
// and compares whenever wb_valid or err pulses.
module tb_r_format_mc_cpu;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic        iv, rdy, wbv, er;
  logic [31:0] instr, pc, wbd, dd;
  logic [4:0]  wba, da;
  // small instance
  logic        s_iv, s_rdy, s_wbv, s_er;
  logic [31:0] s_instr;
  logic [7:0]  s_pc;
  logic [2:0]  s_wba, s_da;
  logic [15:0] s_wbd, s_dd;

  r_format_mc_cpu dut (
    .clk(clk), .rst_n(rst_n), .instr_valid(iv), .instr(instr),
    .instr_ready(rdy), .pc_out(pc), .wb_valid(wbv), .wb_addr(wba),
    .wb_data(wbd), .err(er), .dbg_addr(da), .dbg_data(dd)
  );

  r_format_mc_cpu #(.DATA_W(16), .REG_NUM(8), .ADDR_W(8), .PC_STEP(4)) dut_s (
    .clk(clk), .rst_n(rst_n), .instr_valid(s_iv), .instr(s_instr),
    .instr_ready(s_rdy), .pc_out(s_pc), .wb_valid(s_wbv), .wb_addr(s_wba),
    .wb_data(s_wbd), .err(s_er), .dbg_addr(s_da), .dbg_data(s_dd)
  );

  typedef struct {
    bit          is_err;
    logic [4:0]  addr;
    logic [31:0] data;
    int          acc;
  } exp_t;

  exp_t q0[$], q1[$];
  int   errors = 0, checks = 0, cyc = 0, acc0 = 0, acc1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [31:0] r(input int rs, input int rt, input int rd,
                                    input int sh, input int fn, input int op = 0);
    return {6'(op), 5'(rs), 5'(rt), 5'(rd), 5'(sh), 6'(fn)};
  endfunction

  // ---------------- monitors
  always @(negedge clk) begin : mon0
    exp_t e;
    if (rst_n && (wbv || er)) begin
      if (q0.size() == 0) begin
        fail($sformatf("unexpected_out0 wb_valid=%0b err=%0b addr=%0d data=%h",
                       wbv, er, wba, wbd));
      end else begin
        e = q0.pop_front();
        check("err0", {31'd0, er}, {31'd0, e.is_err});
        check("wb_valid0", {31'd0, wbv}, {31'd0, !e.is_err});
        if (!e.is_err) begin
          check("wb_addr0", {27'd0, wba}, {27'd0, e.addr});
          check("wb_data0", wbd, e.data);
        end
        check("latency0", 32'(cyc - e.acc), 32'd3);
      end
    end
  end

  always @(negedge clk) begin : mon1
    exp_t e;
    if (rst_n && (s_wbv || s_er)) begin
      if (q1.size() == 0) begin
        fail($sformatf("unexpected_out1 wb_valid=%0b err=%0b addr=%0d data=%h",
                       s_wbv, s_er, s_wba, s_wbd));
      end else begin
        e = q1.pop_front();
        check("err1", {31'd0, s_er}, {31'd0, e.is_err});
        check("wb_valid1", {31'd0, s_wbv}, {31'd0, !e.is_err});
        if (!e.is_err) begin
          check("wb_addr1", {29'd0, s_wba}, {27'd0, e.addr});
          check("wb_data1", {16'd0, s_wbd}, e.data);
        end
        check("latency1", 32'(cyc - e.acc), 32'd3);
      end
    end
  end

  // ---------------- stimulus helpers
  // Present w until accepted; on acceptance queue the expected writeback.
  task automatic issue(input bit sel, input logic [31:0] w, input bit e_err,
                       input logic [4:0] a, input logic [31:0] d, input bit push = 1'b1);
    int   n = 0;
    exp_t e;
    if (!sel) begin instr = w; iv = 1'b1; end
    else      begin s_instr = w; s_iv = 1'b1; end
    while (!(sel ? s_rdy : rdy) && n < 20) begin
      @(posedge clk); #1; n++;
    end
    if (!(sel ? s_rdy : rdy)) begin
      fail($sformatf("accept_timeout dut%0d instr=%h", sel, w));
      iv = 1'b0; s_iv = 1'b0;
      return;
    end
    @(posedge clk); #1;
    iv = 1'b0; s_iv = 1'b0;
    if (sel) acc1++; else acc0++;
    if (push) begin
      e.is_err = e_err; e.addr = a; e.data = d; e.acc = cyc;
      if (sel) q1.push_back(e); else q0.push_back(e);
    end
  endtask

  task automatic ok0(input logic [31:0] w, input logic [4:0] a, input logic [31:0] d);
    issue(1'b0, w, 1'b0, a, d);
  endtask
  task automatic bad0(input logic [31:0] w);
    issue(1'b0, w, 1'b1, 5'd0, 32'd0);
  endtask
  task automatic ok1(input logic [31:0] w, input logic [4:0] a, input logic [31:0] d);
    issue(1'b1, w, 1'b0, a, d);
  endtask
  task automatic bad1(input logic [31:0] w);
    issue(1'b1, w, 1'b1, 5'd0, 32'd0);
  endtask

  task automatic drain();
    int n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (q0.size() != 0 || q1.size() != 0) begin
      fail($sformatf("drain_timeout pending0=%0d pending1=%0d", q0.size(), q1.size()));
      q0.delete(); q1.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  // ---------------- directed sequence
  initial begin
    rst_n = 1'b0;
    iv = 1'b0; s_iv = 1'b0; instr = '0; s_instr = '0; da = '0; s_da = '0;
    #12;
    check("rst_pc", pc, 32'd0);
    check("rst_wbv_err", {30'd0, wbv, er}, 32'd0);
    check("rst_dbg0", dd, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    check("ready_first", {31'd0, rdy}, 32'd1);
    check("pc_first", pc, 32'd0);

    // add $1,$0,$0 : first instruction, latency checked by the monitor
    ok0(r(0, 0, 1, 0, 'h20), 5'd1, 32'd0);
    check("pc_after_first", pc, 32'd4);
    // build constants from the all-zero register file
    ok0(r(0, 0, 10, 0, 'h27), 5'd10, 32'hFFFF_FFFF);  // nor  $10 = -1
    ok0(r(0, 10, 11, 0, 'h23), 5'd11, 32'd1);         // subu $11 = 1
    ok0(r(0, 11, 12, 2, 'h00), 5'd12, 32'd4);         // sll  $12 = 4
    ok0(r(12, 11, 2, 0, 'h21), 5'd2, 32'd5);          // $2 = 5
    ok0(r(12, 12, 13, 0, 'h21), 5'd13, 32'd8);
    ok0(r(13, 11, 3, 0, 'h23), 5'd3, 32'd7);          // $3 = 7
    ok0(r(2, 3, 4, 0, 'h22), 5'd4, 32'hFFFF_FFFE);    // sub  5-7
    ok0(r(2, 3, 5, 0, 'h2A), 5'd5, 32'd1);            // slt
    ok0(r(4, 2, 5, 0, 'h2B), 5'd5, 32'd0);            // sltu 0xFFFFFFFE<5
    ok0(r(0, 10, 6, 1, 'h02), 5'd6, 32'h7FFF_FFFF);   // $6 = INT_MAX
    bad0(r(6, 6, 7, 0, 'h20));                        // add overflow
    drain();
    da = 5'd7; #1;
    check("dbg7_after_ovf", dd, 32'd0);
    ok0(r(6, 6, 7, 0, 'h21), 5'd7, 32'hFFFF_FFFE);    // addu wraps
    ok0(r(0, 11, 8, 31, 'h00), 5'd8, 32'h8000_0000);
    ok0(r(0, 8, 9, 4, 'h03), 5'd9, 32'hF800_0000);    // sra
    ok0(r(0, 8, 9, 4, 'h02), 5'd9, 32'h0800_0000);    // srl
    bad0(r(2, 3, 9, 0, 'h3F));                        // unlisted funct
    drain();
    da = 5'd9; #1;
    check("dbg9_after_illegal", dd, 32'h0800_0000);
    bad0(r(2, 3, 14, 0, 'h20, 8));                    // op != 0
    bad0(r(8, 11, 14, 0, 'h22));                      // sub MIN-1
    bad0(r(6, 10, 14, 0, 'h22));                      // sub MAX-(-1)
    bad0(r(8, 8, 14, 0, 'h20));                       // add MIN+MIN
    ok0(r(8, 11, 14, 0, 'h23), 5'd14, 32'h7FFF_FFFF); // subu never flags
    ok0(r(2, 3, 15, 0, 'h24), 5'd15, 32'd5);
    ok0(r(2, 3, 15, 0, 'h25), 5'd15, 32'd7);
    ok0(r(2, 3, 15, 0, 'h26), 5'd15, 32'd2);
    ok0(r(2, 3, 15, 0, 'h27), 5'd15, 32'hFFFF_FFF8);
    ok0(r(8, 11, 16, 0, 'h2A), 5'd16, 32'd1);         // signed MIN < 1
    ok0(r(8, 11, 16, 0, 'h2B), 5'd16, 32'd0);
    ok0(r(0, 8, 16, 31, 'h03), 5'd16, 32'hFFFF_FFFF);
    ok0(r(0, 8, 16, 31, 'h02), 5'd16, 32'd1);
    ok0(r(0, 3, 16, 0, 'h00), 5'd16, 32'd7);
    ok0(r(2, 2, 0, 0, 'h21), 5'd0, 32'd10);           // rd=0 still pulses
    drain();
    da = 5'd0; #1;
    check("dbg0_hardwired", dd, 32'd0);
    ok0(r(2, 2, 17, 0, 'h21), 5'd17, 32'd10);
    ok0(r(17, 17, 18, 0, 'h21), 5'd18, 32'd20);       // reads fresh $17
    drain();
    da = 5'd18; #1;
    check("dbg18", dd, 32'd20);

    // idle in FETCH: nothing moves
    da = 5'd2;
    check("idle_pc_before", pc, 32'(acc0 * 4));
    repeat (5) begin
      @(posedge clk); #1;
      check("idle_ready", {31'd0, rdy}, 32'd1);
    end
    check("idle_pc_after", pc, 32'(acc0 * 4));
    check("idle_reg2", dd, 32'd5);

    // reset while the instruction sits in EXEC: it must vanish
    issue(1'b0, r(2, 3, 20, 0, 'h21), 1'b0, 5'd0, 32'd0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("midrst_pc", pc, 32'd0);
    check("midrst_wbv_err", {30'd0, wbv, er}, 32'd0);
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("postrst_pc", pc, 32'd0);
    for (int i = 0; i < 32; i++) begin
      da = 5'(i); #1;
      check($sformatf("postrst_reg%0d", i), dd, 32'd0);
    end

    // narrow variant: 16-bit data, 8 registers, 8-bit PC
    acc1 = 0;
    ok1(r(0, 0, 1, 0, 'h27), 5'd1, 32'h0000_FFFF);
    ok1(r(0, 1, 2, 0, 'h23), 5'd2, 32'd1);
    ok1(r(0, 2, 3, 15, 'h00), 5'd3, 32'h8000);
    ok1(r(0, 3, 4, 4, 'h03), 5'd4, 32'hF800);
    ok1(r(0, 3, 4, 4, 'h02), 5'd4, 32'h0800);
    ok1(r(0, 1, 5, 1, 'h02), 5'd5, 32'h7FFF);
    bad1(r(5, 5, 6, 0, 'h20));
    drain();
    s_da = 3'd6; #1;
    check("s_dbg6_after_ovf", {16'd0, s_dd}, 32'd0);
    ok1(r(5, 5, 6, 0, 'h21), 5'd6, 32'hFFFE);
    ok1(r(0, 1, 7, 16, 'h00), 5'd7, 32'd0);           // shamt >= DATA_W
    ok1(r(0, 3, 7, 20, 'h03), 5'd7, 32'hFFFF);
    ok1(r(0, 3, 7, 16, 'h02), 5'd7, 32'd0);
    ok1(r(3, 2, 7, 0, 'h2A), 5'd7, 32'd1);
    ok1(r(3, 2, 7, 0, 'h2B), 5'd7, 32'd0);
    ok1(r(2, 1, 7, 0, 'h22), 5'd7, 32'd2);            // 1-(-1)
    bad1(r(3, 3, 7, 0, 'h20));                        // 0x8000+0x8000
    bad1(r(2, 3, 7, 0, 'h3F));
    ok1(r(2, 2, 9, 0, 'h21), 5'd1, 32'd2);            // rd 9 -> reg 1
    ok1(r(10, 0, 3, 0, 'h21), 5'd3, 32'd1);           // rs 10 -> reg 2
    while (acc1 < 63) ok1(32'd0, 5'd0, 32'd0);        // sll $0,$0,0
    check("s_pc_fc", {24'd0, s_pc}, 32'h0000_00FC);
    ok1(32'd0, 5'd0, 32'd0);
    check("s_pc_wrap", {24'd0, s_pc}, 32'd0);
    drain();
    s_da = 3'd1; #1;
    check("s_dbg1", {16'd0, s_dd}, 32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
